morse_key_decoder: RTL and testbench

//  Receive side of the Morse link. Samples a hand key and times each press and gap in

---
 rtl/morse_key_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// Morse hand-key receiver: synchronises and debounces the key, times marks and gaps in
// Morse units, and emits ASCII characters (A-Z, 0-9, '?' on error, space on word gap).
module morse_key_decoder #(
    parameter int unsigned CLKS_PER_UNIT = 25000000,
    parameter int unsigned DEBOUNCE_CLKS = 500000,
    parameter int unsigned DASH_UNITS    = 2,
    parameter int unsigned LETTER_GAP    = 3,
    parameter int unsigned WORD_GAP      = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_clean,
    output logic       dot_pulse,
    output logic       dash_pulse,
    output logic       char_valid,
    output logic [7:0] char_ascii,
    output logic       char_err,
    output logic       busy
);

    localparam int unsigned UW  = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
    localparam int unsigned DBW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

    typedef enum logic [1:0] {StIdle, StMark, StSpace, StWordWait} state_e;

    logic           key_meta_q, key_sync_q, key_clean_q, key_prev_q;
    logic [DBW-1:0] db_cnt_q;
    logic [UW-1:0]  unit_cnt_q;
    logic           key_rise, key_fall, key_edge, unit_tick;

    state_e      state_q, state_d;
    logic [3:0]  mark_units_q, mark_units_d;
    logic [3:0]  gap_units_q, gap_units_d, gap_inc;
    logic [4:0]  sym_bits_q, sym_bits_d;
    logic [2:0]  sym_len_q, sym_len_d;
    logic        sym_ovf_q, sym_ovf_d;
    logic        dot_q, dot_d, dash_q, dash_d, valid_q, valid_d, err_q, err_d, is_dash;
    logic [7:0]  ascii_q, ascii_d, lut_char;

    // Synchroniser and debounce: key_clean flips only after a run of differing samples.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q  <= 1'b0;
            key_sync_q  <= 1'b0;
            key_clean_q <= 1'b0;
            key_prev_q  <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_clean_q;
            if (key_sync_q != key_clean_q) begin
                if (db_cnt_q == DBW'(DEBOUNCE_CLKS - 1)) begin
                    key_clean_q <= key_sync_q;
                    db_cnt_q    <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign key_rise = key_clean_q & ~key_prev_q;
    assign key_fall = ~key_clean_q & key_prev_q;
    assign key_edge = key_rise | key_fall;
    // An edge on the wrap cycle restarts the unit and swallows that tick.
    assign unit_tick = (unit_cnt_q == UW'(CLKS_PER_UNIT - 1)) && !key_edge;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            unit_cnt_q <= '0;
        end else if (key_edge || unit_cnt_q == UW'(CLKS_PER_UNIT - 1)) begin
            unit_cnt_q <= '0;
        end else begin
            unit_cnt_q <= unit_cnt_q + 1'b1;
        end
    end

    // Symbol key is {length, elements}; first element sits in the highest used bit.
    always_comb begin
        lut_char = 8'h3F;
        case ({sym_len_q, sym_bits_q})
            {3'd1, 5'b00000}: lut_char = 8'h45;
            {3'd1, 5'b00001}: lut_char = 8'h54;
            {3'd2, 5'b00000}: lut_char = 8'h49;
            {3'd2, 5'b00001}: lut_char = 8'h41;
            {3'd2, 5'b00010}: lut_char = 8'h4E;
            {3'd2, 5'b00011}: lut_char = 8'h4D;
            {3'd3, 5'b00000}: lut_char = 8'h53;
            {3'd3, 5'b00001}: lut_char = 8'h55;
            {3'd3, 5'b00010}: lut_char = 8'h52;
            {3'd3, 5'b00011}: lut_char = 8'h57;
            {3'd3, 5'b00100}: lut_char = 8'h44;
            {3'd3, 5'b00101}: lut_char = 8'h4B;
            {3'd3, 5'b00110}: lut_char = 8'h47;
            {3'd3, 5'b00111}: lut_char = 8'h4F;
            {3'd4, 5'b00000}: lut_char = 8'h48;
            {3'd4, 5'b00001}: lut_char = 8'h56;
            {3'd4, 5'b00010}: lut_char = 8'h46;
            {3'd4, 5'b00100}: lut_char = 8'h4C;
            {3'd4, 5'b00110}: lut_char = 8'h50;
            {3'd4, 5'b00111}: lut_char = 8'h4A;
            {3'd4, 5'b01000}: lut_char = 8'h42;
            {3'd4, 5'b01001}: lut_char = 8'h58;
            {3'd4, 5'b01010}: lut_char = 8'h43;
            {3'd4, 5'b01011}: lut_char = 8'h59;
            {3'd4, 5'b01100}: lut_char = 8'h5A;
            {3'd4, 5'b01101}: lut_char = 8'h51;
            {3'd5, 5'b11111}: lut_char = 8'h30;
            {3'd5, 5'b01111}: lut_char = 8'h31;
            {3'd5, 5'b00111}: lut_char = 8'h32;
            {3'd5, 5'b00011}: lut_char = 8'h33;
            {3'd5, 5'b00001}: lut_char = 8'h34;
            {3'd5, 5'b00000}: lut_char = 8'h35;
            {3'd5, 5'b10000}: lut_char = 8'h36;
            {3'd5, 5'b11000}: lut_char = 8'h37;
            {3'd5, 5'b11100}: lut_char = 8'h38;
            {3'd5, 5'b11110}: lut_char = 8'h39;
            default:          lut_char = 8'h3F;
        endcase
        if (sym_ovf_q) lut_char = 8'h3F;
    end

    assign gap_inc = (gap_units_q == 4'hF) ? 4'hF : gap_units_q + 4'd1;
    assign is_dash = (mark_units_q >= 4'(DASH_UNITS));

    always_comb begin
        state_d      = state_q;
        mark_units_d = mark_units_q;
        gap_units_d  = gap_units_q;
        sym_bits_d   = sym_bits_q;
        sym_len_d    = sym_len_q;
        sym_ovf_d    = sym_ovf_q;
        dot_d        = 1'b0;
        dash_d       = 1'b0;
        valid_d      = 1'b0;
        ascii_d      = ascii_q;
        err_d        = err_q;
        case (state_q)
            StIdle: begin
                if (key_rise) begin
                    state_d      = StMark;
                    mark_units_d = 4'd0;
                end
            end
            StMark: begin
                if (key_fall) begin
                    dash_d      = is_dash;
                    dot_d       = !is_dash;
                    gap_units_d = 4'd0;
                    state_d     = StSpace;
                    if (sym_len_q == 3'd5) begin
                        sym_ovf_d = 1'b1;
                    end else begin
                        sym_bits_d = {sym_bits_q[3:0], is_dash};
                        sym_len_d  = sym_len_q + 3'd1;
                    end
                end else if (unit_tick && mark_units_q != 4'hF) begin
                    mark_units_d = mark_units_q + 4'd1;
                end
            end
            StSpace: begin
                if (key_rise) begin
                    state_d      = StMark;
                    mark_units_d = 4'd0;
                end else if (unit_tick) begin
                    gap_units_d = gap_inc;
                    if (gap_inc == 4'(LETTER_GAP)) begin
                        valid_d    = 1'b1;
                        ascii_d    = lut_char;
                        err_d      = (lut_char == 8'h3F);
                        sym_bits_d = 5'd0;
                        sym_len_d  = 3'd0;
                        sym_ovf_d  = 1'b0;
                        state_d    = StWordWait;
                    end
                end
            end
            StWordWait: begin
                if (key_rise) begin
                    state_d      = StMark;
                    mark_units_d = 4'd0;
                end else if (unit_tick) begin
                    gap_units_d = gap_inc;
                    if (gap_inc == 4'(WORD_GAP)) begin
                        valid_d = 1'b1;
                        ascii_d = 8'h20;
                        err_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mark_units_q <= 4'd0;
            gap_units_q  <= 4'd0;
            sym_bits_q   <= 5'd0;
            sym_len_q    <= 3'd0;
            sym_ovf_q    <= 1'b0;
            dot_q        <= 1'b0;
            dash_q       <= 1'b0;
            valid_q      <= 1'b0;
            ascii_q      <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mark_units_q <= mark_units_d;
            gap_units_q  <= gap_units_d;
            sym_bits_q   <= sym_bits_d;
            sym_len_q    <= sym_len_d;
            sym_ovf_q    <= sym_ovf_d;
            dot_q        <= dot_d;
            dash_q       <= dash_d;
            valid_q      <= valid_d;
            ascii_q      <= ascii_d;
            err_q        <= err_d;
        end
    end

    assign key_clean  = key_clean_q;
    assign dot_pulse  = dot_q;
    assign dash_pulse = dash_q;
    assign char_valid = valid_q;
    assign char_ascii = ascii_q;
    assign char_err   = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with short unit and debounce times.
module tb_morse_key_decoder;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       key_in;
    logic       key_clean, dot_pulse, dash_pulse, char_valid, char_err, busy;
    logic [7:0] char_ascii;

    int n_cmp = 0;
    int n_bad = 0;

    // Event log filled on the falling edge, away from the DUT's active edge.
    int         n_dot = 0, n_dash = 0, n_char = 0, n_excl = 0, n_kc = 0, n_busy = 0;
    logic [8:0] ch_log [0:63];

    morse_key_decoder #(
        .CLKS_PER_UNIT(10),
        .DEBOUNCE_CLKS(3),
        .DASH_UNITS   (2),
        .LETTER_GAP   (3),
        .WORD_GAP     (7)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_clean (key_clean),
        .dot_pulse (dot_pulse),
        .dash_pulse(dash_pulse),
        .char_valid(char_valid),
        .char_ascii(char_ascii),
        .char_err  (char_err),
        .busy      (busy)
    );

    always #5 refclk = ~refclk;

    always @(negedge refclk) begin
        if (dot_pulse === 1'b1) n_dot++;
        if (dash_pulse === 1'b1) n_dash++;
        if (key_clean === 1'b1) n_kc++;
        if (busy === 1'b1) n_busy++;
        if ((int'(dot_pulse === 1'b1) + int'(dash_pulse === 1'b1) + int'(char_valid === 1'b1)) > 1)
            n_excl++;
        if (char_valid === 1'b1) begin
            if (n_char < 64) ch_log[n_char] = {char_err, char_ascii};
            n_char++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] get_ch(input int idx);
        if (idx >= n_char || idx >= 64) return 9'h1FF;
        return ch_log[idx];
    endfunction

    task automatic hold(input logic level, input int cycles);
        key_in = level;
        repeat (cycles) @(negedge refclk);
    endtask

    int b_dot, b_dash, b_char, b_kc, b_busy;

    task automatic mark_base();
        b_dot  = n_dot;
        b_dash = n_dash;
        b_char = n_char;
        b_kc   = n_kc;
        b_busy = n_busy;
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b0;
        repeat (3) @(negedge refclk);
        check("rst_outputs", {28'd0, key_clean, dot_pulse, dash_pulse, char_valid}, 32'd0);
        check("rst_ascii", {23'd0, char_err, char_ascii}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge refclk);

        // Letter A: dot then dash, then word gap.
        mark_base();
        hold(1'b1, 15);
        hold(1'b0, 15);
        check("a_busy_in_gap", {31'd0, busy}, 32'd1);
        hold(1'b1, 35);
        hold(1'b0, 40);
        check("a_dots", n_dot - b_dot, 1);
        check("a_dashes", n_dash - b_dash, 1);
        check("a_char", {23'd0, get_ch(b_char)}, {23'd0, 9'h041});
        hold(1'b0, 50);
        check("a_space", {23'd0, get_ch(b_char + 1)}, {23'd0, 9'h020});
        check("a_nchar", n_char - b_char, 2);

        // Letter E followed by a word gap in one release.
        mark_base();
        hold(1'b1, 15);
        hold(1'b0, 80);
        check("e_char", {23'd0, get_ch(b_char)}, {23'd0, 9'h045});
        check("e_space", {23'd0, get_ch(b_char + 1)}, {23'd0, 9'h020});
        check("e_busy_end", {31'd0, busy}, 32'd0);
        check("e_dots", n_dot - b_dot, 1);

        // Short glitch must not reach key_clean.
        mark_base();
        hold(1'b1, 2);
        hold(1'b0, 30);
        check("glitch_kc", n_kc - b_kc, 0);
        check("glitch_strobes", (n_dot - b_dot) + (n_dash - b_dash) + (n_char - b_char), 0);
        check("glitch_busy", n_busy - b_busy, 0);

        // Five dots is the digit 5, still within the symbol store.
        mark_base();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 15);
            hold(1'b0, (i == 4) ? 90 : 15);
        end
        check("five_dots", n_dot - b_dot, 5);
        check("five_char", {23'd0, get_ch(b_char)}, {23'd0, 9'h035});

        // Six dots overflows the store.
        mark_base();
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 15);
            hold(1'b0, (i == 5) ? 40 : 15);
        end
        check("ovf_dots", n_dot - b_dot, 6);
        check("ovf_char", {23'd0, get_ch(b_char)}, {23'd0, 9'h13F});
        hold(1'b0, 50);
        check("ovf_space_err_clr", {23'd0, get_ch(b_char + 1)}, {23'd0, 9'h020});

        // Dot-dot-dash-dash has no table entry.
        mark_base();
        hold(1'b1, 15); hold(1'b0, 15);
        hold(1'b1, 15); hold(1'b0, 15);
        hold(1'b1, 35); hold(1'b0, 15);
        hold(1'b1, 35); hold(1'b0, 40);
        check("udd_dots", n_dot - b_dot, 2);
        check("udd_dashes", n_dash - b_dash, 2);
        check("udd_char", {23'd0, get_ch(b_char)}, {23'd0, 9'h13F});
        hold(1'b0, 50);

        // Reset in the middle of a letter gap discards the partial symbol.
        mark_base();
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 15);
            hold(1'b0, (i == 2) ? 20 : 15);
        end
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ascii", {23'd0, char_err, char_ascii}, 32'd0);
        check("rst_mid_strobes", {28'd0, key_clean, dot_pulse, dash_pulse, char_valid}, 32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
        hold(1'b0, 80);
        check("rst_no_char", n_char - b_char, 0);
        check("rst_ascii_held", {24'd0, char_ascii}, 32'd0);

        check("strobe_exclusive", n_excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
